permutation_rounds: RTL

PERMUTATION_ROUNDS -- requirements
Module: permutation_rounds

---
 rtl/ascon_pack.sv | 19 +
 rtl/couche_diffusion.sv | 24 ++
 rtl/couche_substitution.sv | 44 ++++
 rtl/permutation_rounds.sv | 79 +++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared Ascon definitions: the 5 x 64-bit permutation state, the permutation
// FSM encoding and the round-constant function.
package ascon_pack;

  // Word i of the state is Ascon word xi (x0 = state[0]).
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perm_fsm_t;

  // Round constant injected into the low byte of x2: 0xF0 for round 0, 0x4B for round 11.
  function automatic logic [7:0] round_constant(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

endpackage

// File: rtl/couche_diffusion.sv
// Ascon linear diffusion layer: xi ^= ROR(xi,a) ^ ROR(xi,b) with per-word rotations.
module couche_diffusion
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  logic [63:0] x0, x1, x2, x3, x4;

  assign x0 = state_i[0];
  assign x1 = state_i[1];
  assign x2 = state_i[2];
  assign x3 = state_i[3];
  assign x4 = state_i[4];

  // ROR(x,n) written as {x[n-1:0], x[63:n]}.
  assign state_o[0] = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
  assign state_o[1] = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
  assign state_o[2] = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
  assign state_o[3] = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
  assign state_o[4] = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};

endmodule

// File: rtl/couche_substitution.sv
// Ascon 5-bit S-box applied bit-slice-wise across the five state words.
module couche_substitution
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // Word-wide boolean form of the S-box: every bit position is one independent 5-bit lookup.
  always_comb begin
    x0 = state_i[0];
    x1 = state_i[1];
    x2 = state_i[2];
    x3 = state_i[3];
    x4 = state_i[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;

    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;

    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;

    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o = {x4, x3, x2, x1, x0};
  end

endmodule

// File: rtl/permutation_rounds.sv
// Iterative Ascon permutation: one round per clock from round_init_i up to
// NB_ROUNDS_MAX-1, with a one-cycle done pulse on completion.
module permutation_rounds
  import ascon_pack::*;
#(
  parameter int NB_ROUNDS_MAX = 12
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] round_init_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [3:0] LAST_ROUND = 4'(NB_ROUNDS_MAX - 1);

  perm_fsm_t  fsm_q;
  logic [3:0] r_q;
  type_state  state_q;
  type_state  state_add;
  type_state  state_sub;
  type_state  state_dif;

  always_comb begin
    state_add          = state_q;
    state_add[2][7:0]  = state_q[2][7:0] ^ round_constant(r_q);
  end

  couche_substitution u_substitution (
    .state_i (state_add),
    .state_o (state_sub)
  );

  couche_diffusion u_diffusion (
    .state_i (state_sub),
    .state_o (state_dif)
  );

  // An initial round index past the last round skips RUN and reports the loaded state as-is.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      r_q     <= '0;
      state_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_q <= state_i;
            r_q     <= round_init_i;
            fsm_q   <= (round_init_i > LAST_ROUND) ? DONE : RUN;
          end
        end
        RUN: begin
          state_q <= state_dif;
          r_q     <= r_q + 4'd1;
          if (r_q == LAST_ROUND) begin
            fsm_q <= DONE;
          end
        end
        DONE: begin
          fsm_q <= IDLE;
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  // Status flags decode the FSM register directly so reset clears them without a clock edge.
  assign busy_o  = (fsm_q != IDLE);
  assign done_o  = (fsm_q == DONE);
  assign state_o = state_q;

endmodule
